// File: rtl/cache_refill_arbiter.sv
// Two-requester refill arbiter: I-side and D-side caches share one AXI4 read
// bridge. One burst is in flight at a time. The round-robin grant is held from
// the address handshake through the RLAST beat. BEAT_ERR is a sticky flag that
// reports a burst whose length differs from C_BURST_BEATS.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending ARVALIDs (one cycle)
// ADDR  | owner's address presented to bridge until handshake
// DATA  | owner receives beats by pass-through until RLAST handshake
module cache_refill_arbiter #(
    parameter int C_ADDRESS_WIDTH = 32,
    parameter int C_DATA_WIDTH    = 32,
    parameter int C_BURST_BEATS   = 4
) (
    input  logic                       CLK,
    input  logic                       RES_N,
    input  logic [C_ADDRESS_WIDTH-1:0] S0_ARADDR,
    input  logic                       S0_ARVALID,
    output logic                       S0_ARREADY,
    output logic [C_DATA_WIDTH-1:0]    S0_RDATA,
    output logic                       S0_RVALID,
    output logic                       S0_RLAST,
    input  logic                       S0_RREADY,
    input  logic [C_ADDRESS_WIDTH-1:0] S1_ARADDR,
    input  logic                       S1_ARVALID,
    output logic                       S1_ARREADY,
    output logic [C_DATA_WIDTH-1:0]    S1_RDATA,
    output logic                       S1_RVALID,
    output logic                       S1_RLAST,
    input  logic                       S1_RREADY,
    output logic [C_ADDRESS_WIDTH-1:0] M_ARADDR,
    output logic                       M_ARVALID,
    input  logic                       M_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]    M_RDATA,
    input  logic                       M_RVALID,
    input  logic                       M_RLAST,
    output logic                       M_RREADY,
    output logic [1:0]                 GRANT,
    output logic                       BEAT_ERR
);

    localparam int CNT_W = $clog2(C_BURST_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(C_BURST_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_grant_q, last_grant_d;   // 1 = requester 1 owned the previous burst
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             beat_err_q, beat_err_d;
    logic             r_hs;

    // State, owner, round-robin history, beat counter and sticky error flag.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            beat_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            beat_err_q   <= beat_err_d;
        end
    end

    // Next-state logic plus the owner-steered handshake muxes.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        beat_err_d   = beat_err_q;
        M_ARVALID    = 1'b0;
        M_ARADDR     = '0;
        M_RREADY     = 1'b0;
        S0_ARREADY   = 1'b0;
        S1_ARREADY   = 1'b0;
        S0_RVALID    = 1'b0;
        S1_RVALID    = 1'b0;
        S0_RLAST     = 1'b0;
        S1_RLAST     = 1'b0;
        r_hs         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // With both requesting, the one that did not own the last burst wins.
                if (S0_ARVALID && (!S1_ARVALID || last_grant_q)) begin
                    grant_d = 2'b01;
                    state_d = ST_ADDR;
                end else if (S1_ARVALID) begin
                    grant_d = 2'b10;
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                M_ARVALID  = 1'b1;
                M_ARADDR   = grant_q[1] ? S1_ARADDR : S0_ARADDR;
                S0_ARREADY = grant_q[0] & M_ARREADY;
                S1_ARREADY = grant_q[1] & M_ARREADY;
                if (M_ARREADY) begin
                    beat_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end

            ST_DATA: begin
                M_RREADY  = grant_q[1] ? S1_RREADY : S0_RREADY;
                S0_RVALID = grant_q[0] & M_RVALID;
                S1_RVALID = grant_q[1] & M_RVALID;
                S0_RLAST  = grant_q[0] & M_RLAST;
                S1_RLAST  = grant_q[1] & M_RLAST;
                r_hs      = M_RVALID & M_RREADY;
                if (r_hs) begin
                    if (beat_cnt_q != CNT_MAX) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    // Burst length mismatch in either direction; termination still follows RLAST.
                    if ((M_RLAST && beat_cnt_q != LAST_IDX) ||
                        (!M_RLAST && beat_cnt_q == LAST_IDX)) begin
                        beat_err_d = 1'b1;
                    end
                    if (M_RLAST) begin
                        last_grant_d = grant_q[1];
                        grant_d      = 2'b00;
                        state_d      = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    assign S0_RDATA = M_RDATA;
    assign S1_RDATA = M_RDATA;
    assign GRANT    = grant_q;
    assign BEAT_ERR = beat_err_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Scoreboard bench for cache_refill_arbiter: stimulus pushes the expected
// address handshakes and delivered beats, and a negedge monitor pops and compares them.
module tb_cache_refill_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BB = 4;

    logic          CLK = 1'b0;
    logic          RES_N;
    logic [AW-1:0] S0_ARADDR, S1_ARADDR, M_ARADDR;
    logic          S0_ARVALID, S0_ARREADY, S0_RVALID, S0_RLAST, S0_RREADY;
    logic          S1_ARVALID, S1_ARREADY, S1_RVALID, S1_RLAST, S1_RREADY;
    logic [DW-1:0] S0_RDATA, S1_RDATA, M_RDATA;
    logic          M_ARVALID, M_ARREADY, M_RVALID, M_RLAST, M_RREADY;
    logic [1:0]    GRANT;
    logic          BEAT_ERR;

    cache_refill_arbiter #(
        .C_ADDRESS_WIDTH(AW),
        .C_DATA_WIDTH   (DW),
        .C_BURST_BEATS  (BB)
    ) dut (
        .CLK       (CLK),
        .RES_N     (RES_N),
        .S0_ARADDR (S0_ARADDR),
        .S0_ARVALID(S0_ARVALID),
        .S0_ARREADY(S0_ARREADY),
        .S0_RDATA  (S0_RDATA),
        .S0_RVALID (S0_RVALID),
        .S0_RLAST  (S0_RLAST),
        .S0_RREADY (S0_RREADY),
        .S1_ARADDR (S1_ARADDR),
        .S1_ARVALID(S1_ARVALID),
        .S1_ARREADY(S1_ARREADY),
        .S1_RDATA  (S1_RDATA),
        .S1_RVALID (S1_RVALID),
        .S1_RLAST  (S1_RLAST),
        .S1_RREADY (S1_RREADY),
        .M_ARADDR  (M_ARADDR),
        .M_ARVALID (M_ARVALID),
        .M_ARREADY (M_ARREADY),
        .M_RDATA   (M_RDATA),
        .M_RVALID  (M_RVALID),
        .M_RLAST   (M_RLAST),
        .M_RREADY  (M_RREADY),
        .GRANT     (GRANT),
        .BEAT_ERR  (BEAT_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    grant;
    } ar_exp_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          last;
    } beat_exp_t;

    ar_exp_t   ar_q[$];
    beat_exp_t beat_q[$];
    ar_exp_t   mon_ar;
    beat_exp_t mon_beat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rready(input int port, input logic v);
        if (port == 1) S1_RREADY = v;
        else           S0_RREADY = v;
    endtask

    // Monitor: compare every handshake the DUT is about to complete against the scoreboard.
    always @(negedge CLK) begin
        if (RES_N) begin
            if (M_ARVALID && M_ARREADY) begin
                if (ar_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ar_unexpected actual=%0h required=none", M_ARADDR);
                end else begin
                    mon_ar = ar_q.pop_front();
                    chk("ar_addr", 64'(M_ARADDR), 64'(mon_ar.addr));
                    chk("ar_grant", 64'(GRANT), 64'(mon_ar.grant));
                    chk("ar_ready_owner", 64'({S1_ARREADY, S0_ARREADY}), 64'(mon_ar.grant));
                end
            end
            if (S0_RVALID && S0_RREADY) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL s0_beat_unexpected actual=%0h required=none", S0_RDATA);
                end else begin
                    mon_beat = beat_q.pop_front();
                    chk("s0_beat_port", 64'(0), 64'(mon_beat.port));
                    chk("s0_beat_data", 64'(S0_RDATA), 64'(mon_beat.data));
                    chk("s0_beat_last", 64'(S0_RLAST), 64'(mon_beat.last));
                end
            end
            if (S1_RVALID && S1_RREADY) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL s1_beat_unexpected actual=%0h required=none", S1_RDATA);
                end else begin
                    mon_beat = beat_q.pop_front();
                    chk("s1_beat_port", 64'(1), 64'(mon_beat.port));
                    chk("s1_beat_data", 64'(S1_RDATA), 64'(mon_beat.data));
                    chk("s1_beat_last", 64'(S1_RLAST), 64'(mon_beat.last));
                end
            end
            chk("rvalid_leak", 64'({S1_RVALID & ~GRANT[1], S0_RVALID & ~GRANT[0]}), 64'(0));
        end
    end

    // Bridge model for one burst: wait for the address, accept it, then return beats.
    task automatic serve(input int port, input logic [AW-1:0] addr, input logic [DW-1:0] dbase,
                         input int nbeats, input int exp_wait, input bit drop, input int stall_at);
        int        n;
        ar_exp_t   e;
        beat_exp_t b;
        n       = 0;
        e.addr  = addr;
        e.grant = (port == 1) ? 2'b10 : 2'b01;
        ar_q.push_back(e);
        while (!M_ARVALID && n < 50) begin
            tick();
            n++;
        end
        if (!M_ARVALID) begin
            checks++;
            errors++;
            $display("FAIL ar_timeout actual=no_arvalid required=arvalid port=%0d", port);
            return;
        end
        if (exp_wait >= 0) chk("arb_latency", 64'(n), 64'(exp_wait));
        M_ARREADY = 1'b1;
        tick();
        M_ARREADY = 1'b0;
        if (drop) begin
            if (port == 1) S1_ARVALID = 1'b0;
            else           S0_ARVALID = 1'b0;
        end
        for (int i = 0; i < nbeats; i++) begin
            M_RVALID = 1'b1;
            M_RDATA  = dbase + DW'(i);
            M_RLAST  = (i == nbeats - 1);
            if (i == stall_at) begin
                set_rready(port, 1'b0);
                repeat (3) begin
                    #1;
                    chk("stall_m_rready", 64'(M_RREADY), 64'(0));
                    tick();
                end
                set_rready(port, 1'b1);
            end
            b.port = port;
            b.data = dbase + DW'(i);
            b.last = (i == nbeats - 1);
            beat_q.push_back(b);
            tick();
        end
        M_RVALID = 1'b0;
        M_RLAST  = 1'b0;
        M_RDATA  = '0;
        chk("grant_idle_after_last", 64'(GRANT), 64'(0));
        chk("arvalid_gap_after_last", 64'(M_ARVALID), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 64'(GRANT), 64'(0));
        chk({tag, "_m_arvalid"}, 64'(M_ARVALID), 64'(0));
        chk({tag, "_m_araddr"}, 64'(M_ARADDR), 64'(0));
        chk({tag, "_m_rready"}, 64'(M_RREADY), 64'(0));
        chk({tag, "_s_ready_valid_last"},
            64'({S0_ARREADY, S0_RVALID, S0_RLAST, S1_ARREADY, S1_RVALID, S1_RLAST}), 64'(0));
        chk({tag, "_beat_err"}, 64'(BEAT_ERR), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        ar_exp_t   e;
        beat_exp_t b;
        RES_N      = 1'b0;
        S0_ARADDR  = '0; S0_ARVALID = 1'b0; S0_RREADY = 1'b1;
        S1_ARADDR  = '0; S1_ARVALID = 1'b0; S1_RREADY = 1'b1;
        M_ARREADY  = 1'b0; M_RDATA = '0; M_RVALID = 1'b0; M_RLAST = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        RES_N = 1'b1;

        // Single S0 burst: address on the cycle after the request, four beats.
        S0_ARVALID = 1'b1;
        S0_ARADDR  = 32'h0000_1000;
        serve(0, 32'h0000_1000, 32'hA0, BB, 1, 1'b1, -1);
        chk("t1_beat_err", 64'(BEAT_ERR), 64'(0));

        // Fresh reset, then both request together for two bursts each: S0,S1,S0,S1.
        RES_N = 1'b0;
        tick();
        RES_N = 1'b1;
        S0_ARVALID = 1'b1; S0_ARADDR = 32'h0000_4000;
        S1_ARVALID = 1'b1; S1_ARADDR = 32'h0000_5000;
        serve(0, 32'h0000_4000, 32'hB0, BB, 1, 1'b0, -1);
        serve(1, 32'h0000_5000, 32'hC0, BB, 1, 1'b0, -1);
        serve(0, 32'h0000_4000, 32'hD0, BB, 1, 1'b1, -1);
        serve(1, 32'h0000_5000, 32'hE0, BB, 1, 1'b1, -1);

        // Bridge stalls the address for five cycles while S1 waits; S1 then wins over S0.
        S0_ARVALID = 1'b1; S0_ARADDR = 32'h0000_2000;
        tick();
        S1_ARVALID = 1'b1; S1_ARADDR = 32'h0000_3000;
        repeat (5) begin
            #1;
            chk("stall_m_arvalid", 64'(M_ARVALID), 64'(1));
            chk("stall_m_araddr", 64'(M_ARADDR), 64'(32'h0000_2000));
            chk("stall_grant", 64'(GRANT), 64'(2'b01));
            chk("stall_s1_arready", 64'(S1_ARREADY), 64'(0));
            tick();
        end
        serve(0, 32'h0000_2000, 32'h20, BB, 0, 1'b0, -1);
        serve(1, 32'h0000_3000, 32'h30, BB, 1, 1'b1, -1);
        serve(0, 32'h0000_2000, 32'h40, BB, 1, 1'b1, -1);

        // Owner withholds RREADY for three cycles mid-burst.
        S0_ARVALID = 1'b1; S0_ARADDR = 32'h0000_6000;
        serve(0, 32'h0000_6000, 32'h60, BB, 1, 1'b1, 1);
        chk("rready_stall_beat_err", 64'(BEAT_ERR), 64'(0));

        // Short burst sets the sticky error; a later correct burst leaves it set.
        S1_ARVALID = 1'b1; S1_ARADDR = 32'h0000_7000;
        serve(1, 32'h0000_7000, 32'h70, 2, 1, 1'b1, -1);
        chk("short_burst_beat_err", 64'(BEAT_ERR), 64'(1));
        S0_ARVALID = 1'b1; S0_ARADDR = 32'h0000_8000;
        serve(0, 32'h0000_8000, 32'h80, BB, 1, 1'b1, -1);
        chk("sticky_beat_err", 64'(BEAT_ERR), 64'(1));

        // Reset asserted during beat 1 clears everything without waiting for a clock.
        S0_ARVALID = 1'b1; S0_ARADDR = 32'h0000_9000;
        e.addr = 32'h0000_9000; e.grant = 2'b01;
        ar_q.push_back(e);
        tick();
        M_ARREADY = 1'b1;
        tick();
        M_ARREADY  = 1'b0;
        S0_ARVALID = 1'b0;
        M_RVALID = 1'b1; M_RDATA = 32'h90; M_RLAST = 1'b0;
        b.port = 0; b.data = 32'h90; b.last = 1'b0;
        beat_q.push_back(b);
        tick();
        M_RDATA = 32'h91;
        #1;
        chk("pre_reset_s0_rvalid", 64'(S0_RVALID), 64'(1));
        RES_N = 1'b0;
        #1;
        chk_all_zero("async_reset");
        M_RVALID = 1'b0; M_RDATA = '0;
        tick();
        tick();
        RES_N = 1'b1;
        S1_ARVALID = 1'b1; S1_ARADDR = 32'h0000_A000;
        serve(1, 32'h0000_A000, 32'hB8, BB, 1, 1'b1, -1);
        chk("post_reset_beat_err", 64'(BEAT_ERR), 64'(0));

        repeat (2) tick();
        chk("ar_queue_drained", 64'(ar_q.size()), 64'(0));
        chk("beat_queue_drained", 64'(beat_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
